// File: rtl/analog_pkg.sv
// Shared geometry constants, default colours and the span test used by the
// analog bar renderer for both fill and peak-marker hits.
package analog_pkg;

    localparam int COORD_W = 10;
    localparam int CMP_W   = 11;

    localparam logic [11:0] DEF_FILL_RGB = 12'hFFF;
    localparam logic [11:0] DEF_PEAK_RGB = 12'hF00;
    localparam logic [11:0] DEF_BG_RGB   = 12'h000;

    // Left-growing spans test x+len > ox so the origin column never underflows.
    function automatic logic bar_hit(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] ox,
        input logic [COORD_W-1:0] oy,
        input logic [CMP_W-1:0]   len,
        input logic               dir,
        input logic [COORD_W-1:0] h
    );
        logic [CMP_W-1:0] xe, ye, oxe, oye, he;
        logic             row_hit, col_hit;
        xe  = {1'b0, x};
        ye  = {1'b0, y};
        oxe = {1'b0, ox};
        oye = {1'b0, oy};
        he  = {1'b0, h};
        row_hit = (ye >= oye) && (ye <= oye + he);
        if (dir) begin
            col_hit = (xe + len > oxe) && (xe <= oxe);
        end else begin
            col_hit = (xe >= oxe) && (xe < oxe + len);
        end
        return row_hit && col_hit;
    endfunction

endpackage

// File: rtl/peak_hold_channel.sv
// Per-bar frame-sampled shadow value plus peak-hold tracker with hold time
// and saturating decay that never drops below the newest sample.
module peak_hold_channel #(
    parameter int VALUE_W     = 8,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic [VALUE_W-1:0] value,
    output logic [VALUE_W-1:0] S,
    output logic [VALUE_W-1:0] P
);

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [VALUE_W-1:0] s_q, s_d;
    logic [VALUE_W-1:0] p_q, p_d;
    logic [HOLD_W-1:0]  h_q, h_d;
    logic [VALUE_W:0]   dec;

    always_comb begin
        s_d = s_q;
        p_d = p_q;
        h_d = h_q;
        // Extra MSB acts as the borrow flag for the saturating decay.
        dec = {1'b0, p_q} - (VALUE_W + 1)'(DECAY_STEP);
        if (frame_tick) begin
            s_d = value;
            if (value >= p_q) begin
                p_d = value;
                h_d = HOLD_W'(HOLD_FRAMES);
            end else if (h_q != '0) begin
                h_d = h_q - 1'b1;
            end else begin
                p_d = dec[VALUE_W] ? '0 : dec[VALUE_W-1:0];
                if (p_d < value) begin
                    p_d = value;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= '0;
            p_q <= '0;
            h_q <= '0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
            h_q <= h_d;
        end
    end

    assign S = s_q;
    assign P = p_q;

endmodule

// File: rtl/analog_bar_renderer.sv
// Renders N analog-value bars with peak markers for the VGA overlay; two
// register stages from (x, y) to the bar_on / bar_rgb_data pair.
module analog_bar_renderer
    import analog_pkg::*;
#(
    parameter int unsigned                     NUM_BARS    = 2,
    parameter int                              VALUE_W     = 8,
    parameter int                              LEN_SHIFT   = 1,
    parameter int                              BAR_HEIGHT  = 14,
    parameter logic [NUM_BARS*COORD_W-1:0]     BAR_X       = {10'd312, 10'd35},
    parameter logic [NUM_BARS*COORD_W-1:0]     BAR_Y       = {10'd162, 10'd162},
    parameter logic [NUM_BARS-1:0]             BAR_DIR     = 2'b10,
    parameter int                              HOLD_FRAMES = 30,
    parameter int                              DECAY_STEP  = 4,
    parameter logic [11:0]                     FILL_RGB    = DEF_FILL_RGB,
    parameter logic [11:0]                     PEAK_RGB    = DEF_PEAK_RGB,
    parameter logic [11:0]                     BG_RGB      = DEF_BG_RGB
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [COORD_W-1:0]            x,
    input  logic [COORD_W-1:0]            y,
    input  logic                          frame_tick,
    input  logic [NUM_BARS*VALUE_W-1:0]   values,
    output logic                          bar_on,
    output logic [11:0]                   bar_rgb_data
);

    localparam logic [COORD_W-1:0] HGT = COORD_W'(BAR_HEIGHT);

    logic [VALUE_W-1:0]  shadow [NUM_BARS];
    logic [VALUE_W-1:0]  peak   [NUM_BARS];

    logic [NUM_BARS-1:0] fill_q, fill_d;
    logic [NUM_BARS-1:0] mark_q, mark_d;
    logic                on_q, on_d;
    logic [11:0]         rgb_q, rgb_d;

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        peak_hold_channel #(
            .VALUE_W    (VALUE_W),
            .HOLD_FRAMES(HOLD_FRAMES),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .frame_tick(frame_tick),
            .value     (values[g*VALUE_W +: VALUE_W]),
            .S         (shadow[g]),
            .P         (peak[g])
        );
    end

    always_comb begin
        logic [CMP_W-1:0] len, mlen;
        len    = '0;
        mlen   = '0;
        fill_d = '0;
        mark_d = '0;
        for (int unsigned i = 0; i < NUM_BARS; i++) begin
            len  = CMP_W'(shadow[i] >> LEN_SHIFT);
            mlen = CMP_W'(peak[i] >> LEN_SHIFT);
            fill_d[i] = bar_hit(x, y, BAR_X[i*COORD_W +: COORD_W], BAR_Y[i*COORD_W +: COORD_W],
                                len, BAR_DIR[i], HGT);
            // Single marker column = span of M+1 minus span of M.
            mark_d[i] = (peak[i] != '0)
                && bar_hit(x, y, BAR_X[i*COORD_W +: COORD_W], BAR_Y[i*COORD_W +: COORD_W],
                           mlen + CMP_W'(1), BAR_DIR[i], HGT)
                && !bar_hit(x, y, BAR_X[i*COORD_W +: COORD_W], BAR_Y[i*COORD_W +: COORD_W],
                            mlen, BAR_DIR[i], HGT);
        end
    end

    always_comb begin
        logic found;
        found = 1'b0;
        on_d  = 1'b0;
        rgb_d = BG_RGB;
        for (int unsigned i = 0; i < NUM_BARS; i++) begin
            if (!found && (mark_q[i] || fill_q[i])) begin
                found = 1'b1;
                on_d  = 1'b1;
                rgb_d = mark_q[i] ? PEAK_RGB : FILL_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
            mark_q <= '0;
            on_q   <= 1'b0;
            rgb_q  <= 12'h000;
        end else begin
            fill_q <= fill_d;
            mark_q <= mark_d;
            on_q   <= on_d;
            rgb_q  <= rgb_d;
        end
    end

    assign bar_on       = on_q;
    assign bar_rgb_data = rgb_q;

endmodule

// File: tb/tb_analog_bar_renderer.sv
// Directed bench for analog_bar_renderer: scoreboard of expected pixels fed by
// a reference model plus fixed boundary pixels, compared two cycles later.
module tb_analog_bar_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_tick = 1'b0;
    logic [15:0] values = '0;
    logic        bar_on;
    logic [11:0] bar_rgb_data;

    int n_checks = 0;
    int n_errors = 0;

    int mS[2];
    int mP[2];
    int mH[2];
    int BX[2] = '{35, 312};
    int BY[2] = '{162, 162};
    int BD[2] = '{0, 1};

    typedef struct {
        bit          chk;
        logic        on;
        logic [11:0] rgb;
        int          px;
        int          py;
        string       tag;
    } sb_t;

    sb_t sb[$];

    always #5 clk = ~clk;

    analog_bar_renderer #(
        .NUM_BARS   (2),
        .VALUE_W    (8),
        .LEN_SHIFT  (1),
        .BAR_HEIGHT (14),
        .BAR_X      ({10'd312, 10'd35}),
        .BAR_Y      ({10'd162, 10'd162}),
        .BAR_DIR    (2'b10),
        .HOLD_FRAMES(30),
        .DECAY_STEP (4),
        .FILL_RGB   (12'hFFF),
        .PEAK_RGB   (12'hF00),
        .BG_RGB     (12'h000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .frame_tick  (frame_tick),
        .values      (values),
        .bar_on      (bar_on),
        .bar_rgb_data(bar_rgb_data)
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mS[i] = 0;
            mP[i] = 0;
            mH[i] = 0;
        end
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < 2; i++) begin
            int v;
            int d;
            v = int'(values[i*8 +: 8]);
            mS[i] = v;
            if (v >= mP[i]) begin
                mP[i] = v;
                mH[i] = 30;
            end else if (mH[i] != 0) begin
                mH[i] = mH[i] - 1;
            end else begin
                d = mP[i] - 4;
                if (d < 0) d = 0;
                if (d < v) d = v;
                mP[i] = d;
            end
        end
    endfunction

    task automatic model_pix(input int px, input int py, output logic on, output logic [11:0] rgb);
        on  = 1'b0;
        rgb = 12'h000;
        for (int i = 1; i >= 0; i--) begin
            int  L;
            int  M;
            bit  row;
            bit  fill;
            bit  mk;
            L   = mS[i] / 2;
            M   = mP[i] / 2;
            row = (py >= BY[i]) && (py <= BY[i] + 14);
            if (BD[i] == 0) begin
                fill = (px >= BX[i]) && (px < BX[i] + L);
                mk   = (mP[i] != 0) && (px == BX[i] + M);
            end else begin
                fill = (px <= BX[i]) && (px > BX[i] - L);
                mk   = (mP[i] != 0) && (px == BX[i] - M);
            end
            if (row && mk) begin
                on  = 1'b1;
                rgb = 12'hF00;
            end else if (row && fill) begin
                on  = 1'b1;
                rgb = 12'hFFF;
            end
        end
    endtask

    task automatic check_out(input string tag, input int px, input int py,
                             input logic eon, input logic [11:0] ergb);
        n_checks++;
        assert ({bar_on, bar_rgb_data} === {eon, ergb}) else begin
            n_errors++;
            $display("FAIL %s x=%0d y=%0d: got on=%0b rgb=%h, want on=%0b rgb=%h",
                     tag, px, py, bar_on, bar_rgb_data, eon, ergb);
            $error("pixel compare %s", tag);
        end
    endtask

    task automatic step_e(input int px, input int py, input bit chk, input bit tk,
                          input logic eon, input logic [11:0] ergb, input string tag);
        sb_t e;
        x          = px[9:0];
        y          = py[9:0];
        frame_tick = tk;
        sb.push_back('{chk: chk, on: eon, rgb: ergb, px: px, py: py, tag: tag});
        if (tk) model_tick();
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            if (e.chk) check_out(e.tag, e.px, e.py, e.on, e.rgb);
        end
    endtask

    task automatic step(input int px, input int py, input bit chk, input bit tk, input string tag);
        logic        eon;
        logic [11:0] ergb;
        model_pix(px, py, eon, ergb);
        step_e(px, py, chk, tk, eon, ergb, tag);
    endtask

    task automatic flush();
        step_e(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, "flush");
        step_e(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, "flush");
    endtask

    task automatic tick(input logic [15:0] v);
        values = v;
        step(0, 0, 1'b0, 1'b1, "tick");
    endtask

    task automatic scan(input int py, input int x0, input int x1, input string tag);
        for (int px = x0; px <= x1; px++) step(px, py, 1'b1, 1'b0, tag);
        flush();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", 0, 0, 1'b0, 12'h000);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Bar 0 right-growing, value 200: fill 35..134, marker at 135.
        tick({8'd0, 8'd200});
        scan(165, 30, 140, "b0_scan");
        step_e(34,  165, 1'b1, 1'b0, 1'b0, 12'h000, "b0_before");
        step_e(35,  165, 1'b1, 1'b0, 1'b1, 12'hFFF, "b0_origin");
        step_e(134, 165, 1'b1, 1'b0, 1'b1, 12'hFFF, "b0_fill_end");
        step_e(135, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "b0_marker");
        step_e(136, 165, 1'b1, 1'b0, 1'b0, 12'h000, "b0_after");
        flush();

        // Bar 1 left-growing, value 100: fill 263..312, marker at 262.
        tick({8'd100, 8'd200});
        scan(170, 255, 320, "b1_scan");
        scan(177, 255, 320, "b1_row177");
        step_e(261, 170, 1'b1, 1'b0, 1'b0, 12'h000, "b1_before");
        step_e(262, 170, 1'b1, 1'b0, 1'b1, 12'hF00, "b1_marker");
        step_e(263, 170, 1'b1, 1'b0, 1'b1, 12'hFFF, "b1_fill_start");
        step_e(312, 170, 1'b1, 1'b0, 1'b1, 12'hFFF, "b1_origin");
        step_e(313, 170, 1'b1, 1'b0, 1'b0, 12'h000, "b1_after");
        step_e(300, 176, 1'b1, 1'b0, 1'b1, 12'hFFF, "b1_last_row");
        step_e(300, 177, 1'b1, 1'b0, 1'b0, 12'h000, "b1_row_below");
        step_e(300, 161, 1'b1, 1'b0, 1'b0, 12'h000, "b1_row_above");
        flush();

        // Live values change without frame_tick: nothing visible moves.
        values = {8'd10, 8'd250};
        scan(165, 30, 160, "midframe_b0");
        scan(170, 258, 316, "midframe_b1");
        step_e(135, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "midframe_marker");
        step_e(136, 165, 1'b1, 1'b0, 1'b0, 12'h000, "midframe_nogrow");
        step_e(263, 170, 1'b1, 1'b0, 1'b1, 12'hFFF, "midframe_b1");
        flush();

        // Peak hold then decay on bar 0 with the sample dropped to zero.
        tick({8'd100, 8'd200});
        for (int k = 1; k <= 30; k++) begin
            tick({8'd100, 8'd0});
            step_e(35,  165, 1'b1, 1'b0, 1'b0, 12'h000, "hold_nofill");
            step_e(135, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "hold_marker");
            step(134, 165, 1'b1, 1'b0, "hold_model");
            flush();
        end
        tick({8'd100, 8'd0});
        step_e(133, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "decay_196");
        step_e(135, 165, 1'b1, 1'b0, 1'b0, 12'h000, "decay_old_gone");
        flush();
        for (int k = 0; k < 12; k++) begin
            tick({8'd100, 8'd0});
            scan(165, 30, 136, "decay_scan");
        end

        // Asynchronous reset mid-scan while bar 1 fill is on screen.
        repeat (3) step(300, 170, 1'b1, 1'b0, "pre_reset_lit");
        #3 reset_n = 1'b0;
        #1;
        check_out("reset_async", 300, 170, 1'b0, 12'h000);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_held", 300, 170, 1'b0, 12'h000);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        scan(165, 30, 140, "post_reset_b0");
        scan(170, 255, 320, "post_reset_b1");
        step_e(35,  165, 1'b1, 1'b0, 1'b0, 12'h000, "post_reset_35");
        step_e(312, 170, 1'b1, 1'b0, 1'b0, 12'h000, "post_reset_312");
        flush();

        // Decay floor: peak 50 expired, sample 48 -> peak 48, then 50 reloads hold.
        tick({8'd0, 8'd50});
        for (int k = 0; k < 30; k++) tick({8'd0, 8'd0});
        step_e(60, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "peak50_held");
        flush();
        tick({8'd0, 8'd48});
        step_e(58, 165, 1'b1, 1'b0, 1'b1, 12'hFFF, "floor_fill_end");
        step_e(59, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "floor_marker48");
        step_e(60, 165, 1'b1, 1'b0, 1'b0, 12'h000, "floor_not46");
        scan(165, 30, 70, "floor_scan");
        tick({8'd0, 8'd50});
        tick({8'd0, 8'd0});
        step_e(60, 165, 1'b1, 1'b0, 1'b1, 12'hF00, "reload_marker");
        step_e(58, 165, 1'b1, 1'b0, 1'b0, 12'h000, "reload_no_decay");
        step_e(35, 165, 1'b1, 1'b0, 1'b0, 12'h000, "reload_nofill");
        flush();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
